compare_seq: RTL and testbench

Multi-cycle unsigned magnitude comparator controller for garbled-circuit comparison datapaths. Accepts two N-bit operands through a valid/ready handshake and sequences them LSB-chunk-first through a W-bit subtract-style slice (A + ~B + carry), holding the carry between cycles. Reports `ge`, `gt` and `eq` through a second valid/ready handshake. It sits between the operand source (input-label loader) and the result consumer, trading CHUNKS cycles for a W-bit-wide carry chain.

---
 rtl/compare_seq_pkg.sv | 19 +
 rtl/compare_slice.sv | 27 ++
 rtl/compare_seq.sv | 100 ++++++++++
 tb/tb_compare_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/compare_seq_pkg.sv
// Shared types and width helpers for the multi-cycle magnitude comparator.
package compare_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int chunk_count(input int n, input int w);
      return n / w;
   endfunction

   // A single-chunk operand still needs a 1-bit index register.
   function automatic int idx_width(input int chunks);
      return (chunks > 1) ? $clog2(chunks) : 1;
   endfunction

endpackage

// File: rtl/compare_slice.sv
// W-bit subtract-style slice: carry out of a + ~b + ci, plus chunk equality.
module compare_slice #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic         co,
   output logic         eq
);

   // Explicit ripple chain so only the carry is formed, no unused sum bits.
   function automatic logic ripple_carry(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic         c_in);
      logic c;
      c = c_in;
      for (int i = 0; i < W; i++) begin
         c = (x[i] & ~y[i]) | (c & (x[i] | ~y[i]));
      end
      return c;
   endfunction

   assign co = ripple_carry(a, b, ci);
   assign eq = (a == b);

endmodule

// File: rtl/compare_seq.sv
// Sequences two N-bit operands LSB-chunk-first through one W-bit slice and
// reports unsigned ge/gt/eq through a valid/ready result handshake.
module compare_seq
   import compare_seq_pkg::*;
#(
   parameter int N = 64,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_ge,
   output logic         out_gt,
   output logic         out_eq,
   output logic         busy
);

   localparam int CHUNKS = chunk_count(N, W);
   localparam int IDX_W  = idx_width(CHUNKS);

   state_t           state, state_nxt;
   logic [N-1:0]     sa, sb;
   logic             carry, eq_acc;
   logic [IDX_W-1:0] idx;
   logic             slice_co, slice_eq;
   logic             accept, last_chunk;

   assign accept     = (state == IDLE) && in_valid;
   assign last_chunk = (idx == IDX_W'(CHUNKS - 1));

   compare_slice #(.W(W)) u_slice (
      .a  (sa[W-1:0]),
      .b  (sb[W-1:0]),
      .ci (carry),
      .co (slice_co),
      .eq (slice_eq)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = RUN;
         RUN:     if (last_chunk) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Operand shift registers are pure datapath and carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         sa <= in_a;
         sb <= in_b;
      end else if (state == RUN) begin
         sa <= sa >> W;
         sb <= sb >> W;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry  <= 1'b0;
         eq_acc <= 1'b0;
         idx    <= '0;
         out_ge <= 1'b0;
         out_gt <= 1'b0;
         out_eq <= 1'b0;
      end else if (accept) begin
         carry  <= 1'b1;
         eq_acc <= 1'b1;
         idx    <= '0;
      end else if (state == RUN) begin
         carry  <= slice_co;
         eq_acc <= eq_acc & slice_eq;
         idx    <= idx + 1'b1;
         if (last_chunk) begin
            out_ge <= slice_co;
            out_eq <= eq_acc & slice_eq;
            out_gt <= slice_co & ~(eq_acc & slice_eq);
         end
      end
   end

endmodule

// File: tb/tb_compare_seq.sv
// Bench for compare_seq: vector table, scoreboard, backpressure, reset, CHUNKS=1.
module tb_compare_seq;

   localparam int CHUNKS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [63:0] in_a = '0, in_b = '0;
   logic        out_valid, out_ready = 1'b0;
   logic        out_ge, out_gt, out_eq, busy;

   logic        s_in_valid = 1'b0, s_in_ready;
   logic [15:0] s_in_a = '0, s_in_b = '0;
   logic        s_out_valid, s_out_ready = 1'b1;
   logic        s_out_ge, s_out_gt, s_out_eq, s_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [2:0] exp_q[$];

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  exp;   // {ge, gt, eq}
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   compare_seq #(.N(64), .W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_ge(out_ge), .out_gt(out_gt), .out_eq(out_eq), .busy(busy)
   );

   compare_seq #(.N(16), .W(16)) u_one (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_ge(s_out_ge), .out_gt(s_out_gt), .out_eq(s_out_eq), .busy(s_busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] model(input logic [63:0] a, input logic [63:0] b);
      return {a >= b, a > b, a == b};
   endfunction

   // Scoreboard: a result is compared on the cycle its handshake completes.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %b expected none", {out_ge, out_gt, out_eq});
         end else begin
            check("result", {out_ge, out_gt, out_eq}, exp_q.pop_front());
         end
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 50 && !in_ready; k++) begin
         @(posedge clk); #1;
      end
      if (!in_ready) check("wait_in_ready", in_ready, 1);
   endtask

   task automatic run_vec(input logic [63:0] a, input logic [63:0] b, input logic [2:0] exp);
      int lat;
      wait_idle();
      in_a = a; in_b = b; in_valid = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      check("latency_edges", lat + 1, CHUNKS + 1);
      @(posedge clk); #1;
      check("valid_drop", out_valid, 0);
   endtask

   initial begin
      int acc_cyc[4];
      logic [63:0] pa, pb;
      logic [15:0] sv_a[3], sv_b[3];
      logic [2:0]  sv_e[3];
      int lat;

      vecs[0] = '{64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 3'b110};
      vecs[1] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 3'b101};
      vecs[2] = '{64'h0, 64'h1, 3'b000};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b110};
      vecs[4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110};
      vecs[6] = '{64'h0000_0000_0001_0000, 64'h0000_0000_0001_0001, 3'b000};
      vecs[7] = '{64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0001, 3'b000};
      vecs[8] = '{64'h5, 64'h5, 3'b101};

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_flags", {out_ge, out_gt, out_eq}, 0);
      check("rst_busy", busy, 0);

      // Table vectors, consumer always ready
      out_ready = 1'b1;
      foreach (vecs[i]) run_vec(vecs[i].a, vecs[i].b, vecs[i].exp);

      // Backpressure: result held 10 cycles while a new operand is offered
      out_ready = 1'b0;
      wait_idle();
      in_a = 64'd3; in_b = 64'd2; in_valid = 1'b1;
      exp_q.push_back(3'b110);
      @(posedge clk); #1;
      in_a = 64'd7; in_b = 64'd9;
      for (int k = 0; k < 20 && !out_valid; k++) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < 10; k++) begin
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_flags", {out_ge, out_gt, out_eq}, 3'b110);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_busy", busy, 0);
      check("bp_release_in_ready", in_ready, 1);
      check("bp_hold_flags", {out_ge, out_gt, out_eq}, 3'b110);

      // Back-to-back stream with in_valid held high
      for (int i = 0; i < 4; i++) begin
         pa = {$urandom, $urandom};
         pb = (i == 2) ? pa : {$urandom, $urandom};
         in_a = pa; in_b = pb; in_valid = 1'b1;
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (in_ready) break;
         end
         exp_q.push_back(model(pa, pb));
         acc_cyc[i] = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++) check("issue_interval", acc_cyc[i] - acc_cyc[i-1], CHUNKS + 2);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      check("drain", exp_q.size(), 0);

      // Leave nonzero flags behind, then reset mid-RUN
      run_vec(64'h1234, 64'h1234, 3'b101);
      wait_idle();
      in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_flags", {out_ge, out_gt, out_eq}, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("post_rst_no_valid", out_valid, 0);
         check("post_rst_flags", {out_ge, out_gt, out_eq}, 0);
         @(posedge clk); #1;
      end

      // Single-chunk instance
      sv_a[0] = 16'h8000; sv_b[0] = 16'h7FFF; sv_e[0] = 3'b110;
      sv_a[1] = 16'h7FFF; sv_b[1] = 16'h8000; sv_e[1] = 3'b000;
      sv_a[2] = 16'hA5A5; sv_b[2] = 16'hA5A5; sv_e[2] = 3'b101;
      for (int i = 0; i < 3; i++) begin
         check("one_in_ready", s_in_ready, 1);
         s_in_a = sv_a[i]; s_in_b = sv_b[i]; s_in_valid = 1'b1;
         @(posedge clk); #1;
         s_in_valid = 1'b0;
         lat = 0;
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            lat++;
            if (s_out_valid) break;
         end
         check("one_latency_edges", lat + 1, 2);
         check("one_result", {s_out_ge, s_out_gt, s_out_eq}, sv_e[i]);
         @(posedge clk); #1;
         check("one_valid_pulse", s_out_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
